// File: rtl/ll_stream_relay.sv
// ll_stream_relay
//   Subband relay for one pyramid level. Tokens are buffered in a DEPTH-entry
//   FIFO, one of every DECIM tokens is kept, and each kept token is
//   arithmetically shifted right by SHIFT bits before it is stored.
//
//   Optional build macro: LL_STREAM_RELAY_ROUND_EN
//     When defined, kept tokens are rounded (add half an LSB of the result)
//     before the shift and saturated on positive overflow. When undefined, the
//     shift truncates and no rounding adder exists.
//
// Ports
//   CLK        in   clock, rising edge
//   RESET      in   asynchronous reset, active-high
//   In_DATA    in   signed input token, valid while In_SEND=1
//   In_SEND    in   upstream has a token
//   In_COUNT   in   upstream token count (unused)
//   In_ACK     out  consumes the token on In_DATA this cycle
//   Out_DATA   out  FIFO head, first-word fall-through; holds last value when empty
//   Out_SEND   out  one pulse per emitted token
//   Out_COUNT  out  constant 1
//   Out_RDY    in   downstream can take a token this cycle
//   Out_ACK    in   unused
//   FILL       out  FIFO occupancy, 0..DEPTH
module ll_stream_relay #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int DECIM = 1,
    parameter int SHIFT = 0
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [WIDTH-1:0]         In_DATA,
    input  logic                     In_SEND,
    input  logic [15:0]              In_COUNT,
    output logic                     In_ACK,
    output logic [WIDTH-1:0]         Out_DATA,
    output logic                     Out_SEND,
    output logic [15:0]              Out_COUNT,
    input  logic                     Out_RDY,
    input  logic                     Out_ACK,
    output logic [$clog2(DEPTH):0]   FILL
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = PTR_W + 1;
    localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_hold_cnt;
    logic               w_run;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [FILL_W-1:0]  r_fill;
    logic [WIDTH-1:0]   r_last;
    logic [PH_W-1:0]    r_phase;

    logic               w_keep;
    logic               w_not_full;
    logic               w_push;
    logic               w_pop;
    logic               w_ack;
    logic [WIDTH-1:0]   w_store;
    logic               w_unused;

    assign w_unused = ^{In_COUNT, Out_ACK};

    // Reset is stretched: stay idle for three edges after RESET falls, then run
    // until the next reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE) begin
                r_hold_cnt <= r_hold_cnt + 2'd1;
            end
        end
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        case (r_state)
            ST_IDLE: if (r_hold_cnt == 2'd2) w_state_nxt = ST_RUN;
            ST_RUN:  w_run = 1'b1;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake. Fullness is judged on the occupancy at the start of the
    // cycle, so a same-cycle pop never makes room for a push. Tokens that are
    // being discarded never wait for space.
    assign w_keep     = (r_phase == '0);
    assign w_not_full = (r_fill < FILL_W'(DEPTH));
    assign w_ack      = w_run & In_SEND & (~w_keep | w_not_full);
    assign w_push     = w_ack & w_keep;
    assign w_pop      = w_run & (r_fill != '0) & Out_RDY;

    assign In_ACK    = w_ack;
    assign Out_SEND  = w_pop;
    assign Out_COUNT = 16'h0001;
    assign FILL      = r_fill;

    // Empty FIFO shows the last popped token (0 after reset).
    assign Out_DATA = (r_fill != '0) ? r_mem[r_rd_ptr] : r_last;

`ifdef LL_STREAM_RELAY_ROUND_EN
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [WIDTH:0] RND  = (SHIFT > 0) ? (WIDTH+1)'(1 << RND_SH) : '0;
    localparam logic signed [WIDTH:0] MAXV = $signed({2'b00, {(WIDTH-1){1'b1}}});

    logic signed [WIDTH:0] w_wide;
    logic signed [WIDTH:0] w_wide_shr;

    // One guard bit keeps the rounding add from wrapping before the shift.
    always_comb begin
        w_wide     = $signed({In_DATA[WIDTH-1], In_DATA}) + RND;
        w_wide_shr = w_wide >>> SHIFT;
        w_store    = w_wide_shr[WIDTH-1:0];
        if (w_wide_shr > MAXV) begin
            w_store = MAXV[WIDTH-1:0];
        end
    end
`else
    assign w_store = $signed(In_DATA) >>> SHIFT;
`endif

    // NOTE: storage array has no reset; FILL and the pointers alone define which entries are valid.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_store;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
            r_last   <= '0;
            r_phase  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
            if (w_ack) begin
                r_phase <= (r_phase == PH_W'(DECIM - 1)) ? '0 : r_phase + 1'b1;
            end
        end
    end

endmodule
